// File: rtl/step_rate_generator.sv
// step_rate_generator: ramped step strobe with accel, cruise and decel-to-stop
module step_rate_generator #(
  parameter int PERIOD_W     = 24,
  parameter int START_PERIOD = 500000,
  parameter int RAMP_STEP    = 25000,
  parameter int TARGET_0     = 400000,
  parameter int TARGET_1     = 250000,
  parameter int TARGET_2     = 150000,
  parameter int TARGET_3     = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_en,
  input  logic [1:0]          speed_sel,
  output logic                step_tick,
  output logic                moving,
  output logic                at_speed,
  output logic [PERIOD_W-1:0] cur_period,
  output logic [15:0]         step_count
);
  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_e;
  localparam logic [PERIOD_W-1:0] SP = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] RS = PERIOD_W'(RAMP_STEP);
  localparam logic [PERIOD_W-1:0] T0 = PERIOD_W'(TARGET_0);
  localparam logic [PERIOD_W-1:0] T1 = PERIOD_W'(TARGET_1);
  localparam logic [PERIOD_W-1:0] T2 = PERIOD_W'(TARGET_2);
  localparam logic [PERIOD_W-1:0] T3 = PERIOD_W'(TARGET_3);
  localparam logic [PERIOD_W:0]   SP_X = {1'b0, SP};
  state_e state_q, state_d, run_state;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, cur_period_q, cur_period_d;
  logic [PERIOD_W-1:0] tgt, ramp_down, ramp_up, ramp_stop, next_run;
  logic [PERIOD_W:0] up_sum;
  logic [15:0] step_count_q, step_count_d;
  // tick detection and the clamped ramp candidates, one period step toward the goal
  always_comb begin
    tgt = speed_sel == 2'd0 ? T0 : speed_sel == 2'd1 ? T1 : speed_sel == 2'd2 ? T2 : T3;
    step_tick = state_q != IDLE && cnt_q == cur_period_q - PERIOD_W'(1);
    up_sum = {1'b0, cur_period_q} + {1'b0, RS};
    ramp_down = {1'b0, cur_period_q} > {1'b0, tgt} + {1'b0, RS} ? cur_period_q - RS : tgt;
    ramp_up = up_sum < {1'b0, tgt} ? up_sum[PERIOD_W-1:0] : tgt;
    ramp_stop = up_sum < SP_X ? up_sum[PERIOD_W-1:0] : SP;
    next_run = tgt < cur_period_q ? ramp_down : tgt > cur_period_q ? ramp_up : cur_period_q;
    run_state = next_run == tgt ? CRUISE : tgt < cur_period_q ? ACCEL : DECEL;
  end
  // next state: period and ramp decisions only at a tick, except a run_en drop
  always_comb begin
    state_d = state_q;
    cur_period_d = cur_period_q;
    cnt_d = state_q == IDLE || step_tick ? '0 : cnt_q + PERIOD_W'(1);
    step_count_d = step_count_q + 16'(step_tick);
    if (state_q == IDLE) begin
      state_d = run_en ? ACCEL : IDLE;
      cur_period_d = SP;
    end else if (step_tick && !run_en) begin
      state_d = cur_period_q >= SP ? IDLE : DECEL;
      cur_period_d = cur_period_q >= SP ? SP : ramp_stop;
    end else if (step_tick) begin
      state_d = run_state;
      cur_period_d = next_run;
    end else if (!run_en) begin
      state_d = DECEL;
    end
  end
  // state, counter and period registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cur_period_q <= SP;
      step_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cur_period_q <= cur_period_d;
      step_count_q <= step_count_d;
    end
  end
  assign moving = state_q != IDLE;
  assign at_speed = state_q == CRUISE;
  assign cur_period = cur_period_q;
  assign step_count = step_count_q;
endmodule

// File: tb/tb_step_rate_generator.sv
// tb_step_rate_generator: tick-spacing scoreboard over a table of ramp scenarios
module tb_step_rate_generator;
  localparam int SP = 100;
  typedef struct {
    int run;
    int sel;
    int gap;
    int per;
    int spd;
    int mov;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run_en = 1'b1;
  logic [1:0] speed_sel = 2'd3;
  logic step_tick, moving, at_speed;
  logic [23:0] cur_period;
  logic [15:0] step_count;
  int cyc = 0;
  int ref_cyc = 0;
  int seen = 0;
  int n_vec = 0;
  int n_err = 0;
  vec_t tbl [30];
  vec_t sb [$];

  step_rate_generator #(
    .PERIOD_W(24), .START_PERIOD(SP), .RAMP_STEP(20),
    .TARGET_0(100), .TARGET_1(80), .TARGET_2(60), .TARGET_3(40)
  ) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .speed_sel(speed_sel),
    .step_tick(step_tick), .moving(moving), .at_speed(at_speed),
    .cur_period(cur_period), .step_count(step_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    seen <= reset ? 0 : seen + (step_tick ? 1 : 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    int got;
    run_en = v.run[0];
    speed_sel = v.sel[1:0];
    if (!moving) ref_cyc = cyc;
    sb.push_back(v);
    got = 0;
    for (int i = 0; i < 2 * SP + 20 && got == 0; i++) begin
      @(negedge clk);
      got = step_tick ? 1 : 0;
    end
    e = sb.pop_front();
    if (got == 0) chk($sformatf("v%0d_tick_seen", idx), got, 1);
    else chk($sformatf("v%0d_gap", idx), cyc - ref_cyc, e.gap);
    ref_cyc = cyc;
    @(negedge clk);
    chk($sformatf("v%0d_period", idx), int'(cur_period), e.per);
    chk($sformatf("v%0d_at_speed", idx), int'(at_speed), e.spd);
    chk($sformatf("v%0d_moving", idx), int'(moving), e.mov);
    chk($sformatf("v%0d_tick_width", idx), int'(step_tick), 0);
  endtask

  initial begin
    int s0;
    tbl[0]  = '{1, 3, 100,  80, 0, 1};
    tbl[1]  = '{1, 3,  80,  60, 0, 1};
    tbl[2]  = '{1, 3,  60,  40, 1, 1};
    tbl[3]  = '{1, 3,  40,  40, 1, 1};
    tbl[4]  = '{0, 3,  40,  60, 0, 1};
    tbl[5]  = '{0, 3,  60,  80, 0, 1};
    tbl[6]  = '{0, 3,  80, 100, 0, 1};
    tbl[7]  = '{0, 3, 100, 100, 0, 0};
    tbl[8]  = '{1, 3, 100,  80, 0, 1};
    tbl[9]  = '{1, 3,  80,  60, 0, 1};
    tbl[10] = '{1, 3,  60,  40, 1, 1};
    tbl[11] = '{1, 3,  40,  40, 1, 1};
    tbl[12] = '{1, 1,  40,  60, 0, 1};
    tbl[13] = '{1, 1,  60,  80, 1, 1};
    tbl[14] = '{1, 1,  80,  80, 1, 1};
    tbl[15] = '{1, 3,  80,  60, 0, 1};
    tbl[16] = '{1, 3,  60,  40, 1, 1};
    tbl[17] = '{1, 3,  40,  40, 1, 1};
    tbl[18] = '{0, 3,  40,  60, 0, 1};
    tbl[19] = '{1, 3,  60,  40, 1, 1};
    tbl[20] = '{1, 3,  40,  40, 1, 1};
    tbl[21] = '{1, 0,  40,  60, 0, 1};
    tbl[22] = '{1, 0,  60,  80, 0, 1};
    tbl[23] = '{1, 0,  80, 100, 1, 1};
    tbl[24] = '{1, 0, 100, 100, 1, 1};
    tbl[25] = '{1, 3, 100,  80, 0, 1};
    tbl[26] = '{1, 0,  80, 100, 1, 1};
    tbl[27] = '{1, 3, 100,  80, 0, 1};
    tbl[28] = '{1, 0, 100, 100, 1, 1};
    tbl[29] = '{1, 0, 100, 100, 1, 1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_tick", int'(step_tick), 0);
      chk("reset_moving", int'(moving), 0);
      chk("reset_at_speed", int'(at_speed), 0);
      chk("reset_period", int'(cur_period), 100);
      chk("reset_count", int'(step_count), 0);
    end
    reset = 1'b0;
    run_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_moving", int'(moving), 0);
    chk("idle_count", int'(step_count), 0);
    for (int i = 0; i < 8; i++) apply(tbl[i], i);
    s0 = seen;
    repeat (150) @(negedge clk);
    chk("stopped_ticks", seen - s0, 0);
    chk("stopped_moving", int'(moving), 0);
    chk("stopped_count", int'(step_count), 8);
    chk("stopped_count_vs_seen", int'(step_count), seen);
    for (int i = 8; i < 28; i++) apply(tbl[i], i);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midramp_reset_moving", int'(moving), 0);
    chk("midramp_reset_at_speed", int'(at_speed), 0);
    chk("midramp_reset_period", int'(cur_period), 100);
    chk("midramp_reset_count", int'(step_count), 0);
    chk("midramp_reset_tick", int'(step_tick), 0);
    reset = 1'b0;
    speed_sel = 2'd0;
    for (int i = 28; i < 30; i++) apply(tbl[i], i);
    chk("final_count", int'(step_count), 2);
    chk("final_count_vs_seen", int'(step_count), seen);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/step_rate_generator.md
Name: step_rate_generator

Overview:
- Upstream neighbour of the motor motion state machine.
- Produces the one-cycle step strobe that drives its `indicator` input, so it decides when the coil pattern advances.
- Applies a linear period ramp: accelerates on start, cruises at the selected speed, and decelerates before stopping.
- Speed is chosen from board switches; the strobe period changes only at step boundaries.

Parameters:
- PERIOD_W, 24, width of the period counter and period registers.
- START_PERIOD, 500000, step period in clk cycles at start and stop; slowest speed.
- RAMP_STEP, 25000, period change applied per step while ramping.
- TARGET_0, 400000, cruise period for speed_sel=0.
- TARGET_1, 250000, cruise period for speed_sel=1.
- TARGET_2, 150000, cruise period for speed_sel=2.
- TARGET_3, 100000, cruise period for speed_sel=3.
- Legal range: every TARGET_n must satisfy 2 ≤ TARGET_n ≤ START_PERIOD, and RAMP_STEP ≥ 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- run_en  input  1  level: 1 = motor should run, 0 = ramp down and stop.
- speed_sel  input  2  cruise speed select; sampled only at step boundaries.
- step_tick  output  1  one-cycle strobe; connects to the motion state machine's indicator.
- moving  output  1  high whenever the state is not IDLE.
- at_speed  output  1  high in CRUISE.
- cur_period  output  PERIOD_W  period in use for the current step interval.
- step_count  output  16  number of step_tick pulses since reset; wraps at 0xFFFF→0.

Behaviour:
- Reset, sampled on a rising clk edge with reset=1, forces:
  - state=IDLE, cnt=0, cur_period=START_PERIOD
  - step_tick=0, moving=0, at_speed=0, step_count=0
  - reset overrides every other input, including mid-interval and mid-ramp.
- Target period: tgt = TARGET_[speed_sel], evaluated combinationally and used only at a tick.
- Period counter:
  - Outside IDLE, cnt increments every cycle.
  - step_tick=1 in exactly the cycle where cnt==cur_period-1; cnt returns to 0 on the next cycle.
  - Tick spacing is therefore exactly cur_period cycles.
- All cur_period updates and ramp-driven state transitions happen in the tick cycle and take effect for the next interval. The only exception is run_en falling, which changes state immediately.
- States:
  - IDLE:
    - cnt held at 0, no ticks.
    - When run_en=1 is sampled: go to ACCEL with cur_period=START_PERIOD and cnt=0.
    - First tick arrives START_PERIOD cycles after the cycle in which run_en was sampled high.
  - ACCEL:
    - At each tick: cur_period ← max(cur_period − RAMP_STEP, tgt).
    - If the new value equals tgt → CRUISE.
    - If tgt > cur_period at the tick (selection slowed) → DECEL with no stop request.
  - CRUISE:
    - At each tick: if tgt < cur_period → ACCEL; if tgt > cur_period → DECEL; otherwise hold.
  - DECEL:
    - Stopping (run_en=0) at a tick: if cur_period ≥ START_PERIOD → IDLE after emitting this tick; else cur_period ← min(cur_period + RAMP_STEP, START_PERIOD).
    - Slowing (run_en=1) at a tick: cur_period ← min(cur_period + RAMP_STEP, tgt); when equal to tgt → CRUISE.
    - If tgt < cur_period at the tick → ACCEL.
- run_en falling in ACCEL or CRUISE:
  - Go to DECEL on the next edge.
  - The interval in progress completes at its old period; the next tick emits normally.
- run_en rising again while DECEL is stopping: the stop is cancelled, and the next tick resolves toward tgt per the rules above.
- Outputs:
  - moving and at_speed are registered from the state.
  - step_count increments in the tick cycle.
- No tick is ever shorter than TARGET minimum or longer than START_PERIOD.
- speed_sel changes between ticks have no effect until the next tick.

Test Plan:
All scenarios use START_PERIOD=100, RAMP_STEP=20, TARGET_0..3 = 100/80/60/40.

- Reset: hold reset for 3 cycles with run_en=1 → step_tick=0, moving=0, cur_period=100, step_count=0, with no tick during reset.
- Start and accelerate:
  - Stimulus: speed_sel=3, raise run_en at cycle N.
  - First tick at N+100; later tick spacings 80, 60, 40, 40, ….
  - at_speed rises in the cycle after the tick that sets cur_period=40.
- Stop from cruise:
  - Stimulus: drop run_en mid-interval.
  - Remaining tick spacings are 40 (interval completes), 60, 80, 100, then no further ticks.
  - moving falls the cycle after the final tick; step_count equals total ticks.
- Speed change in cruise:
  - Stimulus: at cruise 40, change speed_sel to 1 between ticks.
  - No change until the next tick; then spacings 60, 80, 80 …; at_speed drops during the ramp and returns.
- Restart during stop ramp:
  - Stimulus: speed_sel=3, drop run_en, then re-raise it after the 60-spacing tick.
  - Spacings 40, 60, then re-accelerate 40 with no IDLE gap.
- Reset mid-ramp and minimum-speed case:
  - Assert reset during ACCEL → idle on the next edge.
  - Then speed_sel=0 with run_en=1 → CRUISE after the first tick at 100; spacing constant at 100.
